// File: rtl/matrix_pkg.sv
// Shared codes for the matrix op dispatcher: op codes, response error codes,
// dispatcher state encodings and the command legality check.
package matrix_pkg;

   localparam logic [4:0] MAX_DIM      = 5'd16;
   localparam logic [4:0] MIN_CONV_DIM = 5'd3;

   typedef enum logic [1:0] {
      OP_ADD       = 2'd0,
      OP_MUL       = 2'd1,
      OP_TRANSPOSE = 2'd2,
      OP_CONV      = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_BAD_OP  = 2'd1,
      ERR_BAD_DIM = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_RUN     = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   function automatic err_e check_cmd(input logic [1:0] op, input int num_ops,
                                      input logic [4:0] m, input logic [4:0] n);
      if (int'(op) >= num_ops)                          return ERR_BAD_OP;
      if (m == 5'd0 || m > MAX_DIM)                     return ERR_BAD_DIM;
      if (n == 5'd0 || n > MAX_DIM)                     return ERR_BAD_DIM;
      if (op == OP_CONV && (m < MIN_CONV_DIM || n < MIN_CONV_DIM)) return ERR_BAD_DIM;
      return ERR_OK;
   endfunction

endpackage

// File: rtl/matrix_mem_port_mux.sv
// Combinational NUM_OPS:1 selector of the op units' BRAM strobes, addresses and
// write data; everything reads as zero when the port is not granted.
module matrix_mem_port_mux
   import matrix_pkg::*;
#(
   parameter int NUM_OPS       = 4,
   parameter int ADDR_WIDTH    = 10,
   parameter int ELEMENT_WIDTH = 16
) (
   input  logic [1:0]                       sel,
   input  logic                             active,
   input  logic [NUM_OPS-1:0]               unit_rd_en,
   input  logic [NUM_OPS-1:0]               unit_wr_en,
   input  logic [NUM_OPS*ADDR_WIDTH-1:0]    unit_rd_addr,
   input  logic [NUM_OPS*ADDR_WIDTH-1:0]    unit_wr_addr,
   input  logic [NUM_OPS*ELEMENT_WIDTH-1:0] unit_wr_data,
   output logic                             mem_rd_en,
   output logic                             mem_wr_en,
   output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
   output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
   output logic [ELEMENT_WIDTH-1:0]         mem_wr_data
);

   logic [NUM_OPS-1:0]                    hit;
   logic [NUM_OPS-1:0][ADDR_WIDTH-1:0]    rd_addr_m, wr_addr_m;
   logic [NUM_OPS-1:0][ELEMENT_WIDTH-1:0] wr_data_m;

   // Mask every lane by its grant, then OR-reduce: one lane at most is non-zero.
   for (genvar k = 0; k < NUM_OPS; k++) begin : g_lane
      assign hit[k]       = active && (int'(sel) == k);
      assign rd_addr_m[k] = hit[k] ? unit_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      assign wr_addr_m[k] = hit[k] ? unit_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      assign wr_data_m[k] = hit[k] ? unit_wr_data[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] : '0;
   end

   assign mem_rd_en = |(unit_rd_en & hit);
   assign mem_wr_en = |(unit_wr_en & hit);

   always_comb begin
      mem_rd_addr = '0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      for (int k = 0; k < NUM_OPS; k++) begin
         mem_rd_addr = mem_rd_addr | rd_addr_m[k];
         mem_wr_addr = mem_wr_addr | wr_addr_m[k];
         mem_wr_data = mem_wr_data | wr_data_m[k];
      end
   end

endmodule

// File: rtl/matrix_op_dispatcher.sv
// Single-command sequencer for the matrix op units; owns the shared BRAM port.
// Optional watchdog enabled by defining MATRIX_DISPATCH_TIMEOUT_EN.
module matrix_op_dispatcher
   import matrix_pkg::*;
#(
   parameter int ELEMENT_WIDTH  = 16,
   parameter int ADDR_WIDTH     = 10,
   parameter int NUM_OPS        = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [1:0]                       cmd_op,
   input  logic [4:0]                       cmd_dim_m,
   input  logic [4:0]                       cmd_dim_n,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr_op1,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr_op2,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr_res,
   output logic [NUM_OPS-1:0]               unit_start,
   input  logic [NUM_OPS-1:0]               unit_done,
   output logic [4:0]                       unit_dim_m,
   output logic [4:0]                       unit_dim_n,
   output logic [ADDR_WIDTH-1:0]            unit_addr_op1,
   output logic [ADDR_WIDTH-1:0]            unit_addr_op2,
   output logic [ADDR_WIDTH-1:0]            unit_addr_res,
   input  logic [NUM_OPS-1:0]               unit_rd_en,
   input  logic [NUM_OPS-1:0]               unit_wr_en,
   input  logic [NUM_OPS*ADDR_WIDTH-1:0]    unit_rd_addr,
   input  logic [NUM_OPS*ADDR_WIDTH-1:0]    unit_wr_addr,
   input  logic [NUM_OPS*ELEMENT_WIDTH-1:0] unit_wr_data,
   output logic                             mem_rd_en,
   output logic                             mem_wr_en,
   output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
   output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
   output logic [ELEMENT_WIDTH-1:0]         mem_wr_data,
   output logic                             busy,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [1:0]                       rsp_err,
   output logic [31:0]                      rsp_cycles
);

   state_e       state, state_nxt;
   logic [1:0]   sel;
   logic [31:0]  cnt, cnt_inc;
   err_e         err_q, chk_err;
   logic [NUM_OPS-1:0] sel_oh;
   logic         done_sel, timeout_hit, mem_active;

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_sel
      assign sel_oh[k] = (int'(sel) == k);
   end

   assign done_sel = |(unit_done & sel_oh);
   assign chk_err  = check_cmd(sel, NUM_OPS, unit_dim_m, unit_dim_n);
   assign cnt_inc  = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;

`ifdef MATRIX_DISPATCH_TIMEOUT_EN
   // Fires on the cycle in which start has been high TIMEOUT_CYCLES times.
   assign timeout_hit = (cnt_inc >= 32'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (cmd_valid) state_nxt = ST_CHECK;
         ST_CHECK:   state_nxt = (chk_err == ERR_OK) ? ST_RUN : ST_RESP;
         ST_RUN:     if (done_sel)         state_nxt = ST_RELEASE;
                     else if (timeout_hit) state_nxt = ST_RESP;
         ST_RELEASE: if (!done_sel) state_nxt = ST_RESP;
         ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = (state == ST_IDLE);
      busy       = (state != ST_IDLE);
      rsp_valid  = (state == ST_RESP);
      unit_start = (state == ST_RUN) ? sel_oh : '0;
      mem_active = (state == ST_RUN) || (state == ST_RELEASE);
      rsp_err    = err_q;
   end

   // Command latch, cycle counter and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel           <= '0;
         unit_dim_m    <= '0;
         unit_dim_n    <= '0;
         unit_addr_op1 <= '0;
         unit_addr_op2 <= '0;
         unit_addr_res <= '0;
         cnt           <= '0;
         err_q         <= ERR_OK;
         rsp_cycles    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (cmd_valid) begin
               sel           <= cmd_op;
               unit_dim_m    <= cmd_dim_m;
               unit_dim_n    <= cmd_dim_n;
               unit_addr_op1 <= cmd_addr_op1;
               unit_addr_op2 <= cmd_addr_op2;
               unit_addr_res <= cmd_addr_res;
            end
            ST_CHECK: begin
               cnt        <= '0;
               err_q      <= chk_err;
               rsp_cycles <= '0;
            end
            ST_RUN: begin
               cnt <= cnt_inc;
               if (done_sel) begin
                  rsp_cycles <= cnt_inc;
               end else if (timeout_hit) begin
                  err_q      <= ERR_TIMEOUT;
                  rsp_cycles <= 32'(TIMEOUT_CYCLES);
               end
            end
            default: ;
         endcase
      end
   end

   matrix_mem_port_mux #(
      .NUM_OPS       (NUM_OPS),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .ELEMENT_WIDTH (ELEMENT_WIDTH)
   ) u_mem_mux (
      .sel          (sel),
      .active       (mem_active),
      .unit_rd_en   (unit_rd_en),
      .unit_wr_en   (unit_wr_en),
      .unit_rd_addr (unit_rd_addr),
      .unit_wr_addr (unit_wr_addr),
      .unit_wr_data (unit_wr_data),
      .mem_rd_en    (mem_rd_en),
      .mem_wr_en    (mem_wr_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data)
   );

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// Scoreboard bench for matrix_op_dispatcher: directed commands push expected
// responses, monitors pop and compare on each response handshake.
module tb_matrix_op_dispatcher;

   localparam int EW = 16;
   localparam int AW = 10;
   localparam int NO = 4;
   localparam int N2 = 3;

   typedef struct packed {
      logic [1:0]  err;
      logic [31:0] cycles;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            cmd_valid = 0, cmd_valid2 = 0, cmd_ready, cmd_ready2;
   logic [1:0]      cmd_op = 0;
   logic [4:0]      cmd_dim_m = 0, cmd_dim_n = 0;
   logic [AW-1:0]   cmd_addr_op1 = 0, cmd_addr_op2 = 0, cmd_addr_res = 0;
   logic            rsp_ready = 1;

   logic [NO-1:0]    unit_start, unit_done;
   logic [4:0]       unit_dim_m, unit_dim_n;
   logic [AW-1:0]    unit_addr_op1, unit_addr_op2, unit_addr_res;
   logic [NO-1:0]    unit_rd_en = 0, unit_wr_en = 0;
   logic [NO*AW-1:0] unit_rd_addr = 0, unit_wr_addr = 0;
   logic [NO*EW-1:0] unit_wr_data = 0;
   logic             mem_rd_en, mem_wr_en, busy, rsp_valid;
   logic [AW-1:0]    mem_rd_addr, mem_wr_addr;
   logic [EW-1:0]    mem_wr_data;
   logic [1:0]       rsp_err;
   logic [31:0]      rsp_cycles;

   logic [N2-1:0]    s2_start;
   logic [N2-1:0]    s2_zero1 = 0;
   logic [N2*AW-1:0] s2_zero_a = 0;
   logic [N2*EW-1:0] s2_zero_d = 0;
   logic [4:0]       s2_dm, s2_dn;
   logic [AW-1:0]    s2_a1, s2_a2, s2_ar, s2_mra, s2_mwa;
   logic [EW-1:0]    s2_mwd;
   logic             s2_mre, s2_mwe, s2_busy, rsp_valid2;
   logic [1:0]       rsp_err2;
   logic [31:0]      rsp_cycles2;

   matrix_op_dispatcher #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .NUM_OPS(NO)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_dim_m(cmd_dim_m), .cmd_dim_n(cmd_dim_n),
      .cmd_addr_op1(cmd_addr_op1), .cmd_addr_op2(cmd_addr_op2), .cmd_addr_res(cmd_addr_res),
      .unit_start(unit_start), .unit_done(unit_done),
      .unit_dim_m(unit_dim_m), .unit_dim_n(unit_dim_n),
      .unit_addr_op1(unit_addr_op1), .unit_addr_op2(unit_addr_op2), .unit_addr_res(unit_addr_res),
      .unit_rd_en(unit_rd_en), .unit_wr_en(unit_wr_en),
      .unit_rd_addr(unit_rd_addr), .unit_wr_addr(unit_wr_addr), .unit_wr_data(unit_wr_data),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_err(rsp_err), .rsp_cycles(rsp_cycles));

   // Three-unit instance: op code 3 is out of range here.
   matrix_op_dispatcher #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .NUM_OPS(N2)) dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_op(cmd_op), .cmd_dim_m(cmd_dim_m), .cmd_dim_n(cmd_dim_n),
      .cmd_addr_op1(cmd_addr_op1), .cmd_addr_op2(cmd_addr_op2), .cmd_addr_res(cmd_addr_res),
      .unit_start(s2_start), .unit_done(s2_zero1),
      .unit_dim_m(s2_dm), .unit_dim_n(s2_dn),
      .unit_addr_op1(s2_a1), .unit_addr_op2(s2_a2), .unit_addr_res(s2_ar),
      .unit_rd_en(s2_zero1), .unit_wr_en(s2_zero1),
      .unit_rd_addr(s2_zero_a), .unit_wr_addr(s2_zero_a), .unit_wr_data(s2_zero_d),
      .mem_rd_en(s2_mre), .mem_wr_en(s2_mwe), .mem_rd_addr(s2_mra),
      .mem_wr_addr(s2_mwa), .mem_wr_data(s2_mwd),
      .busy(s2_busy), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
      .rsp_err(rsp_err2), .rsp_cycles(rsp_cycles2));

   // Op unit model: done after done_after[k] start-high cycles, held while start high.
   int            done_after [NO];
   int            ucnt [NO];
   int            start_cnt [NO];
   logic [NO-1:0] done_force = 0;

   initial for (int k = 0; k < NO; k++) begin
      done_after[k] = 1; ucnt[k] = 0; start_cnt[k] = 0;
   end

   always @(posedge clk) begin
      for (int k = 0; k < NO; k++) begin
         ucnt[k] <= unit_start[k] ? ucnt[k] + 1 : 0;
         if (unit_start[k]) start_cnt[k] <= start_cnt[k] + 1;
      end
   end

   always_comb begin
      unit_done = done_force;
      for (int k = 0; k < NO; k++)
         if (unit_start[k] && (ucnt[k] + 1 >= done_after[k])) unit_done[k] = 1'b1;
   end

   int   checks = 0, errors = 0;
   rsp_t exp_q[$], exp2_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin : mon0
         rsp_t e;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got err=%0d cycles=%0d expected none", rsp_err, rsp_cycles);
         end else begin
            e = exp_q.pop_front();
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_cycles", 64'(rsp_cycles), 64'(e.cycles));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && rsp_valid2 && rsp_ready) begin : mon2
         rsp_t e;
         if (exp2_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp2: got err=%0d cycles=%0d expected none", rsp_err2, rsp_cycles2);
         end else begin
            e = exp2_q.pop_front();
            check("rsp2_err", 64'(rsp_err2), 64'(e.err));
            check("rsp2_cycles", 64'(rsp_cycles2), 64'(e.cycles));
         end
      end
   end

   // Drive a command at a negedge; accepted on the following posedge.
   task automatic send(input logic [1:0] op, input logic [4:0] m, input logic [4:0] n,
                       input logic [1:0] eerr, input int ecyc);
      int t;
      @(negedge clk);
      cmd_op = op; cmd_dim_m = m; cmd_dim_n = n;
      cmd_addr_op1 = 10'h100; cmd_addr_op2 = 10'h200; cmd_addr_res = 10'h300;
      cmd_valid = 1'b1;
      exp_q.push_back('{err: eerr, cycles: 32'(ecyc)});
      t = 0;
      while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
      check("cmd_accept", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int t = 0;
      do begin @(negedge clk); t++; end while (!(cmd_ready && !rsp_valid) && t < limit);
      check("return_to_idle", 64'(cmd_ready && !rsp_valid), 64'd1);
   endtask

   initial begin : watchdog
      #300000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stim
      int base;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_unit_start", 64'(unit_start), 64'd0);
      check("rst_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
      check("rst_rsp_cycles", 64'(rsp_cycles), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // ADD 2x2, done after 10 cycles
      done_after[0] = 10; base = start_cnt[0];
      send(2'd0, 5'd2, 5'd2, 2'd0, 10);
      wait_idle(100);
      check("add_start_cycles", 64'(start_cnt[0] - base), 64'd10);

      // CONV 2x5: rejected, response two cycles after accept, no start
      base = start_cnt[3];
      send(2'd3, 5'd2, 5'd5, 2'd2, 0);
      @(negedge clk);
      check("conv_bad_rsp_not_yet", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("conv_bad_rsp_valid", 64'(rsp_valid), 64'd1);
      wait_idle(20);
      check("conv_bad_no_start", 64'(start_cnt[3] - base), 64'd0);

      send(2'd0, 5'd17, 5'd2, 2'd2, 0); wait_idle(20);
      send(2'd1, 5'd0, 5'd4, 2'd2, 0);  wait_idle(20);

      // CONV 3x3 is the smallest legal conv
      done_after[3] = 4;
      send(2'd3, 5'd3, 5'd3, 2'd0, 4); wait_idle(50);

      // ADD 16x16 while a non-selected unit asserts done
      done_after[0] = 6; done_force[2] = 1'b1;
      send(2'd0, 5'd16, 5'd16, 2'd0, 6); wait_idle(50);
      done_force[2] = 1'b0;

      done_after[0] = 1;
      send(2'd0, 5'd1, 5'd1, 2'd0, 1); wait_idle(50);

      // MUL memory path: unit1 owns the port, unit0 strobes ignored
      unit_wr_en = 4'b0011; unit_rd_en = 4'b0001;
      unit_wr_addr[0*AW +: AW] = 10'h33; unit_wr_addr[1*AW +: AW] = 10'h20;
      unit_wr_data[0*EW +: EW] = 16'h0011; unit_wr_data[1*EW +: EW] = 16'h005A;
      unit_rd_addr[0*AW +: AW] = 10'h44;
      @(negedge clk);
      check("idle_mem_wr_en", 64'(mem_wr_en), 64'd0);
      check("idle_mem_addr", 64'({mem_wr_addr, mem_rd_addr}), 64'd0);
      done_after[1] = 20;
      send(2'd1, 5'd3, 5'd3, 2'd0, 20);
      @(negedge clk);
      check("check_mem_wr_en", 64'(mem_wr_en), 64'd0);
      check("latched_dim_m", 64'(unit_dim_m), 64'd3);
      check("latched_addr_res", 64'(unit_addr_res), 64'h300);
      @(negedge clk);
      check("run_unit_start", 64'(unit_start), 64'b0010);
      check("run_mem_wr_en", 64'(mem_wr_en), 64'd1);
      check("run_mem_wr_addr", 64'(mem_wr_addr), 64'h20);
      check("run_mem_wr_data", 64'(mem_wr_data), 64'h5A);
      check("run_mem_rd_en", 64'(mem_rd_en), 64'd0);
      check("run_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
      wait_idle(100);
      unit_wr_en = 0; unit_rd_en = 0;

      // Response held for 5 cycles; a command offered meanwhile is ignored
      rsp_ready = 1'b0; done_after[2] = 7;
      send(2'd2, 5'd4, 5'd16, 2'd0, 7);
      begin
         int t = 0;
         while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
      end
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dim_m = 5'd2; cmd_dim_n = 5'd2;
      for (int i = 0; i < 5; i++) begin
         check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
         check("hold_rsp_err", 64'(rsp_err), 64'd0);
         check("hold_rsp_cycles", 64'(rsp_cycles), 64'd7);
         check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      wait_idle(20);

      // Bad op code on the three-unit instance
      @(negedge clk);
      cmd_op = 2'd3; cmd_dim_m = 5'd4; cmd_dim_n = 5'd4; cmd_valid2 = 1'b1;
      exp2_q.push_back('{err: 2'd1, cycles: 32'd0});
      @(posedge clk); #1; cmd_valid2 = 1'b0;
      begin
         int t = 0;
         while (exp2_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
      end
      check("dut3_no_start", 64'(s2_start), 64'd0);

      // Reset mid-RUN drops start and strobes immediately
      done_after[1] = 1000; unit_wr_en = 4'b0010; unit_rd_en = 4'b0010;
      send(2'd1, 5'd5, 5'd5, 2'd0, 0);
      repeat (4) @(negedge clk);
      check("pre_rst_start", 64'(unit_start), 64'b0010);
      check("pre_rst_mem_wr_en", 64'(mem_wr_en), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_start", 64'(unit_start), 64'd0);
      check("rst_mid_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
      check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      void'(exp_q.pop_back());
      @(negedge clk); rst_n = 1'b1;
      unit_wr_en = 0; unit_rd_en = 0;

      done_after[0] = 3; base = start_cnt[0];
      send(2'd0, 5'd2, 5'd2, 2'd0, 3); wait_idle(50);
      check("post_rst_start_cycles", 64'(start_cnt[0] - base), 64'd3);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("scoreboard2_drained", 64'(exp2_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
